// File: rtl/viterbi_chan_pkg.sv
// Shared types and helpers for the viterbi burst channel model.
// Used by viterbi_burst_channel and viterbi_lfsr32.
package viterbi_chan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GUARD = 2'd2
    } chan_state_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v,
                                              input logic [1:0]  inc);
        logic [16:0] s;
        s = {1'b0, v} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/viterbi_lfsr32.sv
// 32-bit right-shifting Galois LFSR, advanced only when adv_i is high.
// Shared with the BER checker so both sides see the same sequence.
module viterbi_lfsr32
    import viterbi_chan_pkg::*;
#(
    parameter logic [31:0] seed = 32'hACE1_2B2F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv_i,
    output logic [31:0] state_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_o <= seed;
        end else if (adv_i) begin
            state_o <= {1'b0, state_o[31:1]} ^ (state_o[0] ? LFSR_POLY : 32'd0);
        end
    end

endmodule

// File: rtl/viterbi_burst_channel.sv
// Burst-error channel between encoder2 and the decoder, with BER counters.
// Define VITERBI_CHAN_RAND_MASK_EN to draw per-symbol masks from the LFSR.
module viterbi_burst_channel
    import viterbi_chan_pkg::*;
#(
    parameter int          N         = 3,
    parameter int          BURST_LEN = 1,
    parameter int          GUARD_LEN = 2,
    parameter int          MAX_WORDS = 256,
    parameter logic [1:0]  ERR_MASK  = 2'b10,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2B2F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  sym_i,
    input  logic        valid_i,
    input  logic        force_err_i,
    output logic [1:0]  sym_o,
    output logic        valid_o,
    output logic [1:0]  err_o,
    output logic        inj_active_o,
    output logic [15:0] word_ct_o,
    output logic [15:0] sym_err_ct_o,
    output logic [15:0] bit_err_ct_o
);

    localparam logic [15:0] BURST_END = 16'(BURST_LEN);
    localparam logic [15:0] GUARD_END = 16'(GUARD_LEN);
    localparam chan_state_e AFTER_BURST = (GUARD_LEN > 0) ? GUARD : IDLE;
    localparam chan_state_e AFTER_TRIG  = (BURST_LEN > 1) ? BURST : AFTER_BURST;

    generate
        if (BURST_LEN < 1) begin : g_bad_burst
            $error("BURST_LEN must be at least 1");
        end
        if (N < 1 || N > 16) begin : g_bad_n
            $error("N must be in 1..16");
        end
        if (ERR_MASK == 2'b00) begin : g_bad_mask
            $error("ERR_MASK must be non-zero");
        end
        if (LFSR_SEED == 32'd0) begin : g_bad_seed
            $error("LFSR_SEED must be non-zero");
        end
    endgenerate

    chan_state_e state;
    chan_state_e state_nxt;
    logic [15:0] burst_ct;
    logic [15:0] burst_nxt;
    logic [15:0] guard_ct;
    logic [15:0] guard_nxt;
    logic [31:0] lfsr;
    logic        trig;
    logic        corrupt;
    logic [1:0]  mask_sel;
    logic [1:0]  mask;

    viterbi_lfsr32 #(.seed(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (valid_i),
        .state_o (lfsr)
    );

    // Trigger uses the pre-shift LFSR and the pre-increment word count.
    assign trig = force_err_i ||
                  (({16'd0, word_ct_o} < 32'(MAX_WORDS)) && (&lfsr[N-1:0]));

`ifdef VITERBI_CHAN_RAND_MASK_EN
    logic [1:0] rand_mask;
    assign rand_mask = lfsr[N+1:N];
    assign mask_sel  = (rand_mask == 2'b00) ? ERR_MASK : rand_mask;
`else
    assign mask_sel  = ERR_MASK;
`endif

    assign mask         = corrupt ? mask_sel : 2'b00;
    assign inj_active_o = (state == BURST);

    always_comb begin
        state_nxt = state;
        burst_nxt = burst_ct;
        guard_nxt = guard_ct;
        corrupt   = 1'b0;
        if (valid_i) begin
            unique case (state)
                IDLE: begin
                    if (trig) begin
                        corrupt   = 1'b1;
                        burst_nxt = 16'd1;
                        guard_nxt = 16'd0;
                        state_nxt = AFTER_TRIG;
                    end
                end
                BURST: begin
                    corrupt   = 1'b1;
                    burst_nxt = burst_ct + 16'd1;
                    if (burst_nxt == BURST_END) begin
                        guard_nxt = 16'd0;
                        state_nxt = AFTER_BURST;
                    end
                end
                GUARD: begin
                    guard_nxt = guard_ct + 16'd1;
                    if (guard_nxt == GUARD_END) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            burst_ct     <= 16'd0;
            guard_ct     <= 16'd0;
            sym_o        <= 2'b00;
            valid_o      <= 1'b0;
            err_o        <= 2'b00;
            word_ct_o    <= 16'd0;
            sym_err_ct_o <= 16'd0;
            bit_err_ct_o <= 16'd0;
        end else begin
            state    <= state_nxt;
            burst_ct <= burst_nxt;
            guard_ct <= guard_nxt;
            valid_o  <= valid_i;
            if (valid_i) begin
                sym_o        <= sym_i ^ mask;
                err_o        <= mask;
                word_ct_o    <= sat_inc16(word_ct_o, 2'd1);
                sym_err_ct_o <= sat_inc16(sym_err_ct_o, {1'b0, corrupt});
                bit_err_ct_o <= sat_inc16(bit_err_ct_o, popcount2(mask));
            end else begin
                err_o <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_viterbi_burst_channel.sv
// Scoreboard bench for viterbi_burst_channel: two instances (N=16 and N=1)
// share stimulus; a monitor per instance pops expected symbols from a queue.
module tb_viterbi_burst_channel;

    localparam int          BL    = 3;
    localparam int          GL    = 2;
    localparam int          MAXW  = 256;
    localparam logic [1:0]  EMASK = 2'b10;
    localparam logic [31:0] SEED  = 32'hACE1_2B2F;
    localparam logic [31:0] POLY  = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  sym = 2'b00;
    logic        valid = 1'b0;
    logic        frc = 1'b0;

    logic [1:0]  a_sym, a_err, b_sym, b_err;
    logic        a_valid, a_inj, b_valid, b_inj;
    logic [15:0] a_word, a_serr, a_berr, b_word, b_serr, b_berr;

    int passed = 0;
    int total  = 0;
    int inj_n  = 0;
    bit count_en = 1'b0;
    logic [1:0] last_a = 2'b00;
    logic [1:0] last_b = 2'b00;
    logic [3:0] qa[$];
    logic [3:0] qb[$];

    always #5 clk = ~clk;

    viterbi_burst_channel #(
        .N(16), .BURST_LEN(BL), .GUARD_LEN(GL), .MAX_WORDS(MAXW),
        .ERR_MASK(EMASK), .LFSR_SEED(SEED)
    ) u_a (
        .clk(clk), .rst(rst), .sym_i(sym), .valid_i(valid),
        .force_err_i(frc), .sym_o(a_sym), .valid_o(a_valid),
        .err_o(a_err), .inj_active_o(a_inj), .word_ct_o(a_word),
        .sym_err_ct_o(a_serr), .bit_err_ct_o(a_berr)
    );

    viterbi_burst_channel #(
        .N(1), .BURST_LEN(BL), .GUARD_LEN(GL), .MAX_WORDS(MAXW),
        .ERR_MASK(EMASK), .LFSR_SEED(SEED)
    ) u_b (
        .clk(clk), .rst(rst), .sym_i(sym), .valid_i(valid),
        .force_err_i(frc), .sym_o(b_sym), .valid_o(b_valid),
        .err_o(b_err), .inj_active_o(b_inj), .word_ct_o(b_word),
        .sym_err_ct_o(b_serr), .bit_err_ct_o(b_berr)
    );

    typedef struct packed {
        logic [31:0] lfsr;
        logic [1:0]  st;
        logic [15:0] bct;
        logic [15:0] gct;
        logic [15:0] word;
        logic [15:0] serr;
        logic [15:0] berr;
    } mdl_t;

    mdl_t ma, mb;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic mdl_t mreset();
        mdl_t r;
        r = '0;
        r.lfsr = SEED;
        return r;
    endfunction

    function automatic logic [15:0] sat(input logic [15:0] v, input int inc);
        int s;
        s = int'(v) + inc;
        return (s > 65535) ? 16'hFFFF : 16'(s);
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int n, input logic f,
                                   output logic [1:0] mask);
        mdl_t r;
        logic hit, cor;
        logic [1:0] rm;
        logic [31:0] lowm;
        r = m;
        cor = 1'b0;
        lowm = (32'd1 << n) - 32'd1;
        hit = f || ((m.word < 16'(MAXW)) && ((m.lfsr & lowm) == lowm));
        case (m.st)
            2'd0: if (hit) begin
                cor = 1'b1; r.bct = 16'd1; r.gct = 16'd0;
                r.st = (BL > 1) ? 2'd1 : ((GL > 0) ? 2'd2 : 2'd0);
            end
            2'd1: begin
                cor = 1'b1; r.bct = m.bct + 16'd1;
                if (r.bct == 16'(BL)) begin
                    r.gct = 16'd0;
                    r.st = (GL > 0) ? 2'd2 : 2'd0;
                end
            end
            default: begin
                r.gct = m.gct + 16'd1;
                if (r.gct == 16'(GL)) r.st = 2'd0;
            end
        endcase
`ifdef VITERBI_CHAN_RAND_MASK_EN
        rm = 2'((m.lfsr >> n) & 32'd3);
        if (rm == 2'b00) rm = EMASK;
`else
        rm = EMASK;
`endif
        mask = cor ? rm : 2'b00;
        r.word = sat(m.word, 1);
        r.serr = sat(m.serr, cor ? 1 : 0);
        r.berr = sat(m.berr, int'(mask[0]) + int'(mask[1]));
        r.lfsr = {1'b0, m.lfsr[31:1]} ^ (m.lfsr[0] ? POLY : 32'd0);
        return r;
    endfunction

    task automatic send(input logic [1:0] s, input logic f);
        logic [1:0] mka, mkb;
        @(posedge clk); #1;
        sym = s; valid = 1'b1; frc = f;
        ma = mstep(ma, 16, f, mka);
        mb = mstep(mb, 1, f, mkb);
        qa.push_back({s ^ mka, mka});
        qb.push_back({s ^ mkb, mkb});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            valid = 1'b0; frc = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        valid = 1'b0; frc = 1'b0; rst = 1'b1;
        qa.delete(); qb.delete();
        ma = mreset(); mb = mreset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [3:0] e;
        if (count_en && a_inj) inj_n++;
        if (rst) begin
            last_a = 2'b00;
        end else if (a_valid) begin
            if (qa.size() == 0) begin
                total++;
                $display("FAIL a_unexpected: got valid_o=1 expected no output");
            end else begin
                e = qa.pop_front();
                chk("a_sym", 32'(a_sym), 32'(e[3:2]));
                chk("a_err", 32'(a_err), 32'(e[1:0]));
            end
            last_a = a_sym;
        end else begin
            chk("a_hold", 32'(a_sym), 32'(last_a));
            chk("a_err_idle", 32'(a_err), 32'd0);
        end
    end

    always @(negedge clk) begin
        logic [3:0] e;
        if (rst) begin
            last_b = 2'b00;
        end else if (b_valid) begin
            if (qb.size() == 0) begin
                total++;
                $display("FAIL b_unexpected: got valid_o=1 expected no output");
            end else begin
                e = qb.pop_front();
                chk("b_sym", 32'(b_sym), 32'(e[3:2]));
                chk("b_err", 32'(b_err), 32'(e[1:0]));
            end
            last_b = b_sym;
        end else begin
            chk("b_hold", 32'(b_sym), 32'(last_b));
            chk("b_err_idle", 32'(b_err), 32'd0);
        end
    end

    task automatic chk_b_model(input string tag);
        chk({tag, "_b_word"}, 32'(b_word), 32'(mb.word));
        chk({tag, "_b_serr"}, 32'(b_serr), 32'(mb.serr));
        chk({tag, "_b_berr"}, 32'(b_berr), 32'(mb.berr));
    endtask

    initial begin
        logic [15:0] s0;
        ma = mreset();
        mb = mreset();

        // Reset hold, then 10 idle cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_a_sym", 32'(a_sym), 32'd0);
        rst = 1'b0;
        idle(10);
        chk("t1_a_err", 32'(a_err), 32'd0);
        chk("t1_a_inj", 32'(a_inj), 32'd0);
        chk("t1_a_word", 32'(a_word), 32'd0);
        chk("t1_b_serr", 32'(b_serr), 32'd0);
        chk("t1_a_lfsr", u_a.u_lfsr.state_o, SEED);
        chk("t1_b_lfsr", u_b.u_lfsr.state_o, SEED);

        // Clean path
        for (int i = 0; i < 20; i++) send(2'b01, 1'b0);
        idle(2);
        chk("t2_a_word", 32'(a_word), 32'd20);
        chk("t2_a_serr", 32'(a_serr), 32'd0);
        chk("t2_a_berr", 32'(a_berr), 32'd0);
        chk_b_model("t2");

        // Forced burst with force held through the guard
        inj_n = 0;
        count_en = 1'b1;
        for (int i = 0; i < 5; i++) send(2'b11, 1'b1);
        idle(3);
        count_en = 1'b0;
        chk("t3_a_inj_cycles", 32'(inj_n), 32'd2);
        chk("t3_a_word", 32'(a_word), 32'd25);
        chk("t3_a_serr", 32'(a_serr), 32'd3);
`ifndef VITERBI_CHAN_RAND_MASK_EN
        chk("t3_a_berr", 32'(a_berr), 32'd3);
`endif
        chk("t3_a_berr_m", 32'(a_berr), 32'(ma.berr));
        chk_b_model("t3");

        // Valid gaps inside a burst
        send(2'b00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle(3);
            send(2'b00, 1'b0);
        end
        idle(2);
        chk("t4_a_word", 32'(a_word), 32'd30);
        chk("t4_a_serr", 32'(a_serr), 32'd6);
        chk_b_model("t4");

        // Reset after the second burst symbol
        send(2'b10, 1'b1);
        send(2'b10, 1'b0);
        do_reset();
        chk("t5_a_word", 32'(a_word), 32'd0);
        chk("t5_a_serr", 32'(a_serr), 32'd0);
        chk("t5_a_berr", 32'(a_berr), 32'd0);
        chk("t5_a_inj", 32'(a_inj), 32'd0);
        chk("t5_a_valid", 32'(a_valid), 32'd0);
        chk("t5_a_state", 32'(u_a.state), 32'd0);
        chk("t5_a_lfsr", u_a.u_lfsr.state_o, SEED);
        send(2'b10, 1'b0);
        idle(2);
        chk("t5_a_word1", 32'(a_word), 32'd1);
        chk("t5_a_serr1", 32'(a_serr), 32'd0);
        chk_b_model("t5");

        // Past MAX_WORDS: random triggers stop, force still injects
        do_reset();
        for (int i = 0; i < 300; i++) send(2'(i), 1'b0);
        idle(2);
        chk("t6_a_word", 32'(a_word), 32'd300);
        chk("t6_b_word", 32'(b_word), 32'd300);
        chk_b_model("t6");
        s0 = b_serr;
        send(2'b01, 1'b1);
        for (int i = 0; i < 4; i++) send(2'b01, 1'b0);
        idle(2);
        chk("t6_b_force_serr", 32'(b_serr - s0), 32'd3);
        chk_b_model("t6f");

        idle(3);
        chk("qa_empty", 32'(qa.size()), 32'd0);
        chk("qb_empty", 32'(qb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/viterbi_burst_channel.md
Name: viterbi_burst_channel

Overview:
- Channel model between encoder2 (2-bit symbols + valid) and the decoder.
- Registers each encoder symbol and, under a pseudo-random trigger, XORs a burst of BURST_LEN consecutive valid symbols with an error mask.
- After each burst, enforces a clean guard gap before the next trigger.
- Keeps saturating word, symbol-error and bit-error counters for BER scoring downstream.

Parameters:
- N, 3: trigger width; a burst triggers when lfsr[N-1:0] is all ones (probability 2^-N per valid symbol). Legal range 1..16.
- BURST_LEN, 1: consecutive valid symbols corrupted per burst. Must be >= 1; 0 is an elaboration error.
- GUARD_LEN, 2: clean valid symbols forced after a burst before re-arming. 0 is allowed.
- MAX_WORDS, 256: random triggers are allowed only while word_ct_o < MAX_WORDS.
- ERR_MASK, 2'b10: XOR mask applied to corrupted symbols. Must be non-zero.
- LFSR_SEED, 32'hACE1_2B2F: LFSR reset value. Must be non-zero.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- sym_i  in  2  encoder symbol
- valid_i  in  1  sym_i qualifier
- force_err_i  in  1  deterministic trigger, sampled only on a valid_i cycle in IDLE
- sym_o  out  2  channel symbol to decoder
- valid_o  out  1  sym_o qualifier
- err_o  out  2  mask applied to the current sym_o (0 when clean)
- inj_active_o  out  1  high while the FSM is in BURST
- word_ct_o  out  16  valid symbols seen, saturating
- sym_err_ct_o  out  16  corrupted symbols, saturating
- bit_err_ct_o  out  16  flipped bits, saturating

Behaviour:
- Reset (async, rst=1):
  - Outputs: sym_o=0, valid_o=0, err_o=0, all counters=0, inj_active_o=0.
  - Internal: FSM=IDLE, LFSR=LFSR_SEED, burst/guard counters=0.
  - Reset asserted mid-burst abandons the burst immediately.
- Latency: 1 cycle.
  - valid_o <= valid_i.
  - On a valid cycle: sym_o <= sym_i ^ mask and err_o <= mask.
  - On a non-valid cycle: sym_o holds and err_o <= 0.
- Advance rule: the LFSR, FSM and all counters advance only on valid_i cycles; everything holds otherwise.
- LFSR: 32-bit Galois, polynomial 0x80200003, shifted once per valid symbol. The trigger test uses the pre-shift value.
- FSM states IDLE, BURST, GUARD; mask is 0 unless stated.
  - IDLE, trigger when valid_i and (force_err_i, or (word_ct_o < MAX_WORDS and lfsr[N-1:0]=='1)):
    - This symbol is corrupted (first burst symbol); burst_ct <= 1.
    - Next state: BURST if BURST_LEN > 1; else GUARD if GUARD_LEN > 0; else IDLE.
  - BURST, per valid symbol:
    - Corrupt it; burst_ct++.
    - When burst_ct reaches BURST_LEN, go to GUARD (GUARD_LEN > 0) or IDLE; guard_ct <= 0.
  - GUARD, per valid symbol:
    - Pass it clean; guard_ct++.
    - At GUARD_LEN, go to IDLE.
    - Triggers, including force_err_i, are ignored in GUARD and BURST.
- inj_active_o is combinational from the state (BURST only). It is low on a single-symbol burst (BURST_LEN=1).
- Counters:
  - word_ct_o +1 per valid symbol.
  - sym_err_ct_o +1 per corrupted symbol.
  - bit_err_ct_o +popcount(mask).
  - All saturate at 16'hFFFF, with no wrap.
  - The MAX_WORDS comparison uses the pre-increment value.
- Simultaneous events: force_err_i together with a random trigger counts as one trigger.

Optional Feature:
- Macro VITERBI_CHAN_RAND_MASK_EN.
  - Defined: the mask for each corrupted symbol is lfsr[N+1:N]; a value of 2'b00 is replaced by ERR_MASK, so a corrupted symbol never passes clean.
  - Undefined: the mask is always ERR_MASK.
- Counter rules are unchanged in both modes.

Decomposition:
- Package viterbi_chan_pkg:
  - chan_state_e enum {IDLE, BURST, GUARD}.
  - LFSR_POLY constant = 32'h8020_0003.
  - popcount2 function.
  - sat_inc16 function.
- Sub-module viterbi_lfsr32:
  - Ports: clk, rst, adv_i, seed (parameter), state_o[31:0].
  - Reused by the BER checker.

Test Plan:
1. Reset hold, then release with valid_i=0 for 10 cycles -> all outputs 0 and the LFSR unchanged (equals LFSR_SEED).
2. Clean path, N=16, 20 valid symbols 2'b01 -> sym_o=01 one cycle later each time, err_o=0, word_ct_o=20, sym_err_ct_o=0.
3. Forced burst (BURST_LEN=3, GUARD_LEN=2, N=1), with force_err_i on valid symbol k -> symbols k..k+2 XOR 10 and k+3,k+4 clean even with force_err_i held high. inj_active_o is high on exactly 2 output cycles; sym_err_ct_o=3, bit_err_ct_o=3.
4. valid_i gaps inside the burst (3 idle cycles between corrupted symbols) -> the burst still covers exactly 3 valid symbols; err_o=0 and sym_o held during the gaps.
5. Reset pulse after the 2nd burst symbol -> counters 0, state IDLE; the next valid symbol without force passes clean unless a random trigger fires (check against a reference LFSR model).
6. word_ct_o past MAX_WORDS=256, N=1, 300 symbols -> no corruption after symbol 256 unless force_err_i; force still injects. With the macro defined, every err_o is in {01,10,11} and bit_err_ct_o equals the sum of popcounts of err_o.
